// File: rtl/bp_fe_bht_tourney.sv
// Tournament branch-direction predictor: bimodal, gshare and chooser counter tables
// with one-cycle predict latency and a valid/yumi training port.
module bp_fe_bht_tourney #(
    parameter  int vaddr_width_p = 39,
    parameter  int idx_width_p   = 8,
    parameter  int ghist_width_p = 8,
    parameter  int ctr_width_p   = 2,
    parameter  int mode_p        = 2,
    localparam int meta_width_lp = 3*ctr_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     init_done_o,

    input  logic                     r_v_i,
    input  logic [vaddr_width_p-1:0] r_addr_i,
    input  logic [ghist_width_p-1:0] r_ghist_i,
    output logic                     pred_v_o,
    output logic                     pred_o,
    output logic [meta_width_lp-1:0] meta_o,

    input  logic                     w_v_i,
    input  logic [vaddr_width_p-1:0] w_addr_i,
    input  logic [ghist_width_p-1:0] w_ghist_i,
    input  logic [meta_width_lp-1:0] w_meta_i,
    input  logic                     w_taken_i,
    output logic                     w_yumi_o
);

    localparam int entries_lp = 1 << idx_width_p;
    localparam int msb_lp     = ctr_width_p - 1;
    localparam logic [ctr_width_p-1:0] init_ctr_lp = ctr_width_p'((1 << msb_lp) - 1);
    localparam bit use_bim_lp = (mode_p != 1);
    localparam bit use_gsh_lp = (mode_p != 0);
    localparam bit use_cho_lp = (mode_p == 2);

    typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

    state_e                 state_r;
    logic [idx_width_p-1:0] clear_cnt_r;

    // Valid/ready: a read is taken whenever r_v_i is high in run; a write moves only
    // in a cycle where w_v_i & w_yumi_o, and the requester holds w_* until then.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_reset;
            clear_cnt_r <= '0;
        end else begin
            case (state_r)
                e_reset: begin
                    state_r     <= e_clear;
                    clear_cnt_r <= '0;
                end
                e_clear: begin
                    clear_cnt_r <= clear_cnt_r + 1'b1;
                    if (clear_cnt_r == '1)
                        state_r <= e_run;
                end
                default: state_r <= e_run;
            endcase
        end
    end

    function automatic logic [ctr_width_p-1:0] sat_step(input logic [ctr_width_p-1:0] c,
                                                       input logic up);
        if (up)
            return (&c) ? c : c + 1'b1;
        else
            return (|c) ? c - 1'b1 : c;
    endfunction

    logic                   run, clearing, conflict, rd_en;
    logic [idx_width_p-1:0] r_bidx, r_gidx, w_bidx, w_gidx;
    logic [idx_width_p-1:0] wr_bidx, wr_gidx;
    logic [ctr_width_p-1:0] w_bim, w_gsh, w_cho;
    logic [ctr_width_p-1:0] wr_bim, wr_gsh, wr_cho;
    logic                   wr_en, wr_cho_en;
    logic [ctr_width_p-1:0] bim_rd, gsh_rd, cho_rd;
    logic                   pred_v_r;

    assign run      = (state_r == e_run);
    assign clearing = (state_r == e_clear);

    assign r_bidx = r_addr_i[2 +: idx_width_p];
    assign w_bidx = w_addr_i[2 +: idx_width_p];
    assign r_gidx = r_bidx ^ idx_width_p'(r_ghist_i);
    assign w_gidx = w_bidx ^ idx_width_p'(w_ghist_i);

    assign conflict = r_v_i & ((r_bidx == w_bidx) | (r_gidx == w_gidx));
    assign w_yumi_o = run & w_v_i & ~conflict;
    assign rd_en    = run & r_v_i;

    assign w_bim = w_meta_i[0 +: ctr_width_p];
    assign w_gsh = w_meta_i[ctr_width_p +: ctr_width_p];
    assign w_cho = w_meta_i[2*ctr_width_p +: ctr_width_p];

    // The clear sweep shares the write port with training updates.
    assign wr_en     = clearing | w_yumi_o;
    assign wr_cho_en = clearing | (w_yumi_o & (w_bim[msb_lp] ^ w_gsh[msb_lp]));
    assign wr_bidx   = clearing ? clear_cnt_r : w_bidx;
    assign wr_gidx   = clearing ? clear_cnt_r : w_gidx;
    assign wr_bim    = clearing ? init_ctr_lp : sat_step(w_bim, w_taken_i);
    assign wr_gsh    = clearing ? init_ctr_lp : sat_step(w_gsh, w_taken_i);
    assign wr_cho    = clearing ? init_ctr_lp : sat_step(w_cho, w_gsh[msb_lp] == w_taken_i);

    if (use_bim_lp) begin : g_bim
        logic [ctr_width_p-1:0] mem [entries_lp];
        logic [ctr_width_p-1:0] rd_r;
        always_ff @(posedge clk_i)
            if (wr_en) mem[wr_bidx] <= wr_bim;
        always_ff @(posedge clk_i)
            if (reset_i)    rd_r <= '0;
            else if (rd_en) rd_r <= mem[r_bidx];
        assign bim_rd = rd_r;
    end else begin : g_no_bim
        assign bim_rd = '0;
    end

    if (use_gsh_lp) begin : g_gsh
        logic [ctr_width_p-1:0] mem [entries_lp];
        logic [ctr_width_p-1:0] rd_r;
        always_ff @(posedge clk_i)
            if (wr_en) mem[wr_gidx] <= wr_gsh;
        always_ff @(posedge clk_i)
            if (reset_i)    rd_r <= '0;
            else if (rd_en) rd_r <= mem[r_gidx];
        assign gsh_rd = rd_r;
    end else begin : g_no_gsh
        assign gsh_rd = '0;
    end

    if (use_cho_lp) begin : g_cho
        logic [ctr_width_p-1:0] mem [entries_lp];
        logic [ctr_width_p-1:0] rd_r;
        always_ff @(posedge clk_i)
            if (wr_cho_en) mem[wr_bidx] <= wr_cho;
        always_ff @(posedge clk_i)
            if (reset_i)    rd_r <= '0;
            else if (rd_en) rd_r <= mem[r_bidx];
        assign cho_rd = rd_r;
    end else begin : g_no_cho
        assign cho_rd = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) pred_v_r <= 1'b0;
        else         pred_v_r <= rd_en;
    end

    assign init_done_o = run;
    assign pred_v_o    = pred_v_r;
    assign meta_o      = {cho_rd, gsh_rd, bim_rd};

    always_comb begin
        pred_o = bim_rd[msb_lp];
        if (mode_p == 1)
            pred_o = gsh_rd[msb_lp];
        else if (mode_p == 2)
            pred_o = cho_rd[msb_lp] ? gsh_rd[msb_lp] : bim_rd[msb_lp];
    end

    // Address bits outside the index window, and meta fields of absent tables.
    logic unused_bits;
    assign unused_bits = ^{r_addr_i, w_addr_i, w_meta_i};

endmodule
